// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register for an opaque stage payload.
// MODE 0 adds a skid entry so up_ready comes from a flop and does not
// depend on dn_ready; MODE 1 is a single entry whose up_ready is
// combinational. Empty slots present NOP_VALUE downstream. A flush squashes
// every held entry. A saturating counter records back-pressure cycles.
module pipe_stage_buf #(
  parameter int                 DATA_W    = 112,
  parameter logic [DATA_W-1:0]  NOP_VALUE = {DATA_W{1'b0}},
  parameter int                 MODE      = 0,
  parameter int                 CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam bit HAS_SKID = (MODE == 0);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]        state_q;
  logic [1:0]        state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_d;
  logic              up_ready_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              main_valid;
  logic              up_xfer;
  logic              dn_xfer;

  assign main_valid = (state_q != ST_EMPTY);

  assign up_ready  = HAS_SKID ? up_ready_q : (!main_valid || dn_ready);
  assign dn_valid  = main_valid;
  assign dn_data   = main_valid ? main_q : NOP_VALUE;
  assign occupancy = occ_q;
  assign stall_cnt = cnt_q;

  assign up_xfer = up_valid && up_ready;
  assign dn_xfer = dn_valid && dn_ready;

  // Next-state and storage update. A flush wins over any incoming beat.
  // The entry being consumed in the same cycle has already been sampled
  // from the pre-edge dn_data, so dropping it here loses nothing. In MODE 1
  // up_ready in BUSY equals dn_ready, so every up_xfer there also drains
  // main and the FULL branch is never taken.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_xfer) begin
            state_d = ST_BUSY;
            main_d  = up_data;
          end
        end
        ST_BUSY: begin
          if (up_xfer && dn_xfer) begin
            main_d = up_data;
          end else if (up_xfer) begin
            if (HAS_SKID) begin
              state_d = ST_FULL;
              skid_d  = up_data;
            end else begin
              main_d = up_data;
            end
          end else if (dn_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_xfer) begin
            state_d = ST_BUSY;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Entry count that the next state implies.
  always_comb begin
    occ_d = 2'd0;
    case (state_d)
      ST_BUSY: occ_d = 2'd1;
      ST_FULL: occ_d = 2'd2;
      default: occ_d = 2'd0;
    endcase
  end

  // State, payload and registered status; up_ready is decided one cycle
  // early so it never depends on this cycle's dn_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_VALUE;
      skid_q     <= NOP_VALUE;
      up_ready_q <= 1'b1;
      occ_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != ST_FULL);
      occ_q      <= occ_d;
    end
  end

  // Back-pressure counter: a clear beats an increment, and the count sticks
  // at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (dn_valid && !dn_ready && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed bench for pipe_stage_buf. Instance u0 is the
// skid version, u1 is the single-entry version and u2 is a skid version
// with a 4-bit stall counter. Inputs change 1 time unit after a rising
// edge. Outputs are sampled before the next edge.
module tb_pipe_stage_buf;

  localparam int DW = 16;

  logic clk;
  logic rst;

  logic          flush0, up_valid0, up_ready0, dn_valid0, dn_ready0, cnt_clr0;
  logic [DW-1:0] up_data0, dn_data0;
  logic [1:0]    occ0;
  logic [15:0]   cnt0;

  logic          flush1, up_valid1, up_ready1, dn_valid1, dn_ready1, cnt_clr1;
  logic [DW-1:0] up_data1, dn_data1;
  logic [1:0]    occ1;
  logic [15:0]   cnt1;

  logic          flush2, up_valid2, up_ready2, dn_valid2, dn_ready2, cnt_clr2;
  logic [DW-1:0] up_data2, dn_data2;
  logic [1:0]    occ2;
  logic [3:0]    cnt2;

  int checks;
  int errors;

  pipe_stage_buf #(.DATA_W(DW), .MODE(0), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .flush(flush0), .up_valid(up_valid0),
    .up_ready(up_ready0), .up_data(up_data0), .dn_valid(dn_valid0),
    .dn_ready(dn_ready0), .dn_data(dn_data0), .occupancy(occ0),
    .cnt_clr(cnt_clr0), .stall_cnt(cnt0)
  );

  pipe_stage_buf #(.DATA_W(DW), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush1), .up_valid(up_valid1),
    .up_ready(up_ready1), .up_data(up_data1), .dn_valid(dn_valid1),
    .dn_ready(dn_ready1), .dn_data(dn_data1), .occupancy(occ1),
    .cnt_clr(cnt_clr1), .stall_cnt(cnt1)
  );

  pipe_stage_buf #(.DATA_W(DW), .MODE(0), .CNT_W(4)) u2 (
    .clk(clk), .rst(rst), .flush(flush2), .up_valid(up_valid2),
    .up_ready(up_ready2), .up_data(up_data2), .dn_valid(dn_valid2),
    .dn_ready(dn_ready2), .dn_data(dn_data2), .occupancy(occ2),
    .cnt_clr(cnt_clr2), .stall_cnt(cnt2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the upstream side of u0.
  task automatic applyStimulus(input logic v, input logic [DW-1:0] d,
                               input logic rdy, input logic fl);
    up_valid0 = v;
    up_data0  = d;
    dn_ready0 = rdy;
    flush0    = fl;
  endtask

  // Advances one clock edge and then steps just past it.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    cnt_clr0 = 1'b0;
    flush1 = 1'b0; up_valid1 = 1'b0; up_data1 = '0; dn_ready1 = 1'b0; cnt_clr1 = 1'b0;
    flush2 = 1'b0; up_valid2 = 1'b0; up_data2 = '0; dn_ready2 = 1'b0; cnt_clr2 = 1'b0;
    step; step;
    rst = 1'b0;

    // Load one stalled entry, then reset asynchronously in mid-cycle.
    applyStimulus(1'b1, 16'h0055, 1'b0, 1'b0);
    step;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    step; step;
    checkOutput("pre_rst_valid", {31'd0, dn_valid0}, 32'd1);
    checkOutput("pre_rst_cnt", {16'd0, cnt0}, 32'd2);
    applyStimulus(1'b1, 16'h0066, 1'b0, 1'b0);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_dn_valid", {31'd0, dn_valid0}, 32'd0);
    checkOutput("rst_dn_data", {16'd0, dn_data0}, 32'd0);
    checkOutput("rst_occ", {30'd0, occ0}, 32'd0);
    checkOutput("rst_cnt", {16'd0, cnt0}, 32'd0);
    checkOutput("rst_up_ready0", {31'd0, up_ready0}, 32'd1);
    checkOutput("rst_up_ready1", {31'd0, up_ready1}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // Streaming at full rate: each payload appears one cycle after it is sent.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b1, 1'b0);
      step;
      checkOutput("stream_data", {16'd0, dn_data0}, i);
      checkOutput("stream_occ", {30'd0, occ0}, 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step;
    checkOutput("stream_end_valid", {31'd0, dn_valid0}, 32'd0);
    checkOutput("stream_end_data", {16'd0, dn_data0}, 32'd0);
    checkOutput("stream_cnt", {16'd0, cnt0}, 32'd0);

    // Back-pressure: 0xA sits in main and 0xB in skid, then both drain in order.
    applyStimulus(1'b1, 16'h000A, 1'b0, 1'b0);
    step;
    checkOutput("bp_ready_busy", {31'd0, up_ready0}, 32'd1);
    applyStimulus(1'b1, 16'h000B, 1'b0, 1'b0);
    step;
    checkOutput("bp_occ2", {30'd0, occ0}, 32'd2);
    checkOutput("bp_ready_full", {31'd0, up_ready0}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    step; step; step; step;
    checkOutput("bp_cnt5", {16'd0, cnt0}, 32'd5);
    checkOutput("bp_head_a", {16'd0, dn_data0}, 32'h000A);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step;
    checkOutput("bp_then_b", {16'd0, dn_data0}, 32'h000B);
    checkOutput("bp_occ1", {30'd0, occ0}, 32'd1);
    checkOutput("bp_ready_again", {31'd0, up_ready0}, 32'd1);
    step;
    checkOutput("bp_drained", {31'd0, dn_valid0}, 32'd0);
    checkOutput("bp_cnt_hold", {16'd0, cnt0}, 32'd5);

    // Flush in FULL with 0xE offered: everything is squashed and 0xE is dropped.
    applyStimulus(1'b1, 16'h000C, 1'b0, 1'b0);
    step;
    applyStimulus(1'b1, 16'h000D, 1'b0, 1'b0);
    step;
    checkOutput("fl_full", {30'd0, occ0}, 32'd2);
    applyStimulus(1'b1, 16'h000E, 1'b0, 1'b1);
    step;
    checkOutput("fl_occ", {30'd0, occ0}, 32'd0);
    checkOutput("fl_data", {16'd0, dn_data0}, 32'd0);
    checkOutput("fl_valid", {31'd0, dn_valid0}, 32'd0);
    checkOutput("fl_ready", {31'd0, up_ready0}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    step;
    checkOutput("fl_no_e", {31'd0, dn_valid0}, 32'd0);

    // Single-entry mode: up_ready follows dn_ready in the same cycle.
    dn_ready1 = 1'b0; up_valid1 = 1'b1; up_data1 = 16'h0011;
    #1;
    checkOutput("m1_ready_empty", {31'd0, up_ready1}, 32'd1);
    step;
    checkOutput("m1_first", {16'd0, dn_data1}, 32'h0011);
    checkOutput("m1_blocked", {31'd0, up_ready1}, 32'd0);
    dn_ready1 = 1'b1; up_data1 = 16'h0022;
    #1;
    checkOutput("m1_ready_comb", {31'd0, up_ready1}, 32'd1);
    step;
    checkOutput("m1_replace", {16'd0, dn_data1}, 32'h0022);
    checkOutput("m1_occ", {30'd0, occ1}, 32'd1);
    up_data1 = 16'h0033;
    step;
    checkOutput("m1_replace2", {16'd0, dn_data1}, 32'h0033);
    checkOutput("m1_occ2", {30'd0, occ1}, 32'd1);
    up_valid1 = 1'b0;
    step;
    checkOutput("m1_drained", {31'd0, dn_valid1}, 32'd0);

    // Four-bit counter saturates at 15, and a clear during a stall beats the increment.
    up_valid2 = 1'b1; up_data2 = 16'h0077; dn_ready2 = 1'b0;
    step;
    up_valid2 = 1'b0;
    for (int i = 0; i < 20; i++) step;
    checkOutput("cnt_sat", {28'd0, cnt2}, 32'd15);
    cnt_clr2 = 1'b1;
    step;
    checkOutput("cnt_clr", {28'd0, cnt2}, 32'd0);
    cnt_clr2 = 1'b0;
    step;
    checkOutput("cnt_after_clr", {28'd0, cnt2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
